pq_order_checker: RTL

Dequeue-order checker for the 16-bit priority-queue self-test. It sits directly downstream of the priority queue, beside the test controller. It samples every key the controller dequeues and verifies min-priority order (non-decreasing keys). It returns a registered error flag and a check-complete flag that the controller uses to decide between continuing and the DISPLAY state.

---
 rtl/pq_order_checker_if.sv | 47 ++++
 rtl/pq_order_checker.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pq_order_checker_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : pq_order_checker_if
// Description : Bus between the priority-queue test controller and the
//               dequeue-order checker. The controller (master) drives the
//               dequeue strobe together with the queue head key and empty flag.
//               The checker (slave) returns the registered verdict flags, the
//               accepted-dequeue count and the captured failure keys.
//               Signals:
//                 deq        - one-cycle dequeue strobe
//                 pq_data    - queue head key, valid while deq is high
//                 pq_empty   - queue empty flag, sampled with deq
//                 error_comp - sticky failure flag
//                 cteal_15   - pass flag, NCHECK ordered dequeues seen
//                 underflow  - the failure was a deq while empty
//                 checked    - accepted dequeues, saturating at NCHECK
//                 err_prev   - previous key at the first ordering failure
//                 err_cur    - offending key at the first ordering failure
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface pq_order_checker_if #(
    parameter int KW     = 16,
    parameter int NCHECK = 15
);
    localparam int CW = $clog2(NCHECK + 1);

    logic          deq;
    logic [KW-1:0] pq_data;
    logic          pq_empty;
    logic          error_comp;
    logic          cteal_15;
    logic          underflow;
    logic [CW-1:0] checked;
    logic [KW-1:0] err_prev;
    logic [KW-1:0] err_cur;

    modport master (
        output deq, pq_data, pq_empty,
        input  error_comp, cteal_15, underflow, checked, err_prev, err_cur
    );

    modport slave (
        input  deq, pq_data, pq_empty,
        output error_comp, cteal_15, underflow, checked, err_prev, err_cur
    );
endinterface
`default_nettype wire

// File: rtl/pq_order_checker.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : pq_order_checker
// Description : Checks that keys dequeued from a min-priority queue come out in
//               non-decreasing (unsigned, full-width) order. The first accepted
//               key seeds the comparison; every further key must be >= the
//               previous one. NCHECK ordered dequeues give a pass; an
//               out-of-order key or a dequeue from an empty queue gives a
//               failure. Both verdicts are sticky until rst or clear.
//               All outputs are registered: a deq in cycle t shows up in t+1.
//               NCHECK must be at least 2.
// Ports       : clk   - clock
//               rst   - synchronous active-high reset
//               clear - synchronous restart, same effect as rst
//               bus   - pq_order_checker_if slave modport (strobe, key,
//                       empty flag in; verdict, count, failure keys out)
// Option      : PQ_ERR_CAPTURE_EN - when defined, the previous and offending
//               keys of the first ordering failure are captured on
//               err_prev / err_cur; otherwise those outputs are tied to 0.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module pq_order_checker #(
    parameter int KW     = 16,
    parameter int NCHECK = 15
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clear,
    pq_order_checker_if.slave     bus
);
    localparam int            CW         = $clog2(NCHECK + 1);
    localparam logic [CW-1:0] c_ncheck   = CW'(NCHECK);
    localparam logic [CW-1:0] c_one      = CW'(1);
    localparam int            c_pass_bit = 2;
    localparam int            c_fail_bit = 3;

    // One-hot encoding so the verdict outputs come straight off state flops.
    typedef enum logic [3:0] {
        ST_FIRST = 4'b0001,
        ST_TRACK = 4'b0010,
        ST_PASS  = 4'b0100,
        ST_FAIL  = 4'b1000
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [KW-1:0] r_prev;
    logic [KW-1:0] w_prev_nxt;
    logic [CW-1:0] r_checked;
    logic [CW-1:0] w_checked_nxt;
    logic [CW-1:0] w_checked_inc;
    logic          r_underflow;
    logic          w_underflow_nxt;
    logic          w_order_fail;

    assign w_checked_inc = r_checked + c_one;

    always_comb begin
        w_state_nxt     = r_state;
        w_prev_nxt      = r_prev;
        w_checked_nxt   = r_checked;
        w_underflow_nxt = r_underflow;
        w_order_fail    = 1'b0;
        unique case (r_state)
            ST_FIRST: begin
                if (bus.deq) begin
                    if (bus.pq_empty) begin
                        w_state_nxt     = ST_FAIL;
                        w_underflow_nxt = 1'b1;
                    end else begin
                        w_prev_nxt    = bus.pq_data;
                        w_checked_nxt = c_one;
                        w_state_nxt   = (c_ncheck == c_one) ? ST_PASS : ST_TRACK;
                    end
                end
            end
            ST_TRACK: begin
                if (bus.deq) begin
                    if (bus.pq_empty) begin
                        w_state_nxt     = ST_FAIL;
                        w_underflow_nxt = 1'b1;
                    end else if (bus.pq_data < r_prev) begin
                        // Count is frozen at the last good dequeue.
                        w_state_nxt  = ST_FAIL;
                        w_order_fail = 1'b1;
                    end else begin
                        w_prev_nxt    = bus.pq_data;
                        w_checked_nxt = w_checked_inc;
                        if (w_checked_inc == c_ncheck) begin
                            w_state_nxt = ST_PASS;
                        end
                    end
                end
            end
            ST_PASS: begin
                w_state_nxt = ST_PASS;
            end
            ST_FAIL: begin
                w_state_nxt = ST_FAIL;
            end
            default: begin
                w_state_nxt = ST_FIRST;
            end
        endcase
    end

    // clear shares the reset path, so a deq coinciding with it is dropped.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_state     <= ST_FIRST;
            r_prev      <= '0;
            r_checked   <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_prev      <= w_prev_nxt;
            r_checked   <= w_checked_nxt;
            r_underflow <= w_underflow_nxt;
        end
    end

    assign bus.error_comp = r_state[c_fail_bit];
    assign bus.cteal_15   = r_state[c_pass_bit];
    assign bus.underflow  = r_underflow;
    assign bus.checked    = r_checked;

`ifdef PQ_ERR_CAPTURE_EN
    logic [KW-1:0] r_err_prev;
    logic [KW-1:0] r_err_cur;

    // w_order_fail only fires on the TRACK->FAIL edge, so this loads once.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_err_prev <= '0;
            r_err_cur  <= '0;
        end else if (w_order_fail) begin
            r_err_prev <= r_prev;
            r_err_cur  <= bus.pq_data;
        end
    end

    assign bus.err_prev = r_err_prev;
    assign bus.err_cur  = r_err_cur;
`else
    assign bus.err_prev = '0;
    assign bus.err_cur  = '0;
`endif

endmodule
`default_nettype wire
